// File: rtl/fetch_sequencer_pkg.sv
// Shared parameters and state encoding for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned FS_COL     = 16;
    localparam int unsigned FS_TIMEOUT = 8;
    localparam int unsigned WAIT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_REDIRECT = 3'd5,
        ST_WAIT_PC  = 3'd6,
        ST_HALT     = 3'd7
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating 4-bit wait counter shared by the ack and redirect-ack waits.
module fetch_timeout_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = FS_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    logic [WAIT_W-1:0] r_count;
    logic [WAIT_W:0]   w_count_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the cycle whose increment makes the count reach TIMEOUT; independent of
    // i_count_en so the FSM can use it without a combinational loop.
    assign w_count_next = {1'b0, r_count} + 1'b1;
    assign o_expired    = (w_count_next >= (WAIT_W+1)'(TIMEOUT));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: memory request/ack, decoder handshake, branch/jump redirect.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned COL     = FS_COL,
    parameter int unsigned TIMEOUT = FS_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    output logic           readInstruction,
    output logic           resetInstructionMemory,
    output logic           branchExecute,
    output logic           jumpExecute,
    output logic [5:0]     offset,
    output logic [11:0]    offsetJump,
    input  logic [COL-1:0] pc_instr,
    input  logic           readInstructionComplete,
    input  logic           pcSetForBranch,
    output logic [COL-1:0] instrOut,
    output logic           instrValid,
    input  logic           instrReady,
    input  logic           redirectValid,
    input  logic           redirectIsJump,
    input  logic [11:0]    redirectOffset,
    output logic           redirectAccepted,
    output logic           halted,
    output logic [15:0]    fetchCount
);

    fetch_state_t   r_state;
    fetch_state_t   w_next;
    logic [COL-1:0] r_instr;
    logic           r_redir_jump;
    logic [11:0]    r_redir_off;
    logic [15:0]    r_fetch_count;

    logic w_accept;
    logic w_handshake;
    logic w_capture;
    logic w_wait_clear;
    logic w_wait_en;
    logic w_expired;

    fetch_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_wait_clear),
        .i_count_en(w_wait_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        w_capture    = 1'b0;
        w_wait_clear = 1'b0;
        w_wait_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (redirectValid) begin
                    w_accept = 1'b1;
                    w_next   = ST_REDIRECT;
                end else if (enable) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_wait_clear = 1'b1;
                w_next       = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (readInstructionComplete) begin
                    w_capture = 1'b1;
                    w_next    = ST_CLEAR;
                end else begin
                    w_wait_en = 1'b1;
                    if (w_expired) w_next = ST_HALT;
                end
            end
            ST_CLEAR: w_next = ST_HOLD;
            ST_HOLD: begin
                if (instrReady) begin
                    w_handshake = 1'b1;
                    if (redirectValid) begin
                        w_accept = 1'b1;
                        w_next   = ST_REDIRECT;
                    end else if (enable) begin
                        w_next = ST_REQ;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_REDIRECT: begin
                w_wait_clear = 1'b1;
                w_next       = ST_WAIT_PC;
            end
            ST_WAIT_PC: begin
                if (pcSetForBranch) begin
                    w_next = enable ? ST_REQ : ST_IDLE;
                end else begin
                    w_wait_en = 1'b1;
                    if (w_expired) w_next = ST_HALT;
                end
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_redir_jump  <= 1'b0;
            r_redir_off   <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) r_instr <= pc_instr;
            if (w_handshake) r_fetch_count <= r_fetch_count + 16'd1;
            if (w_accept) begin
                r_redir_jump <= redirectIsJump;
                r_redir_off  <= redirectOffset;
            end
        end
    end

    assign readInstruction        = (r_state == ST_REQ) || (r_state == ST_WAIT_ACK);
    assign resetInstructionMemory = (r_state == ST_CLEAR);
    assign instrValid             = (r_state == ST_HOLD);
    assign branchExecute          = (r_state == ST_REDIRECT) && !r_redir_jump;
    assign jumpExecute            = (r_state == ST_REDIRECT) && r_redir_jump;
    assign halted                 = (r_state == ST_HALT);
    // Acceptance is decoded from the IDLE state, so it must be masked while reset is held.
    assign redirectAccepted       = w_accept && rst_n;
    assign offset                 = r_redir_off[5:0];
    assign offsetJump             = r_redir_off;
    assign instrOut               = r_instr;
    assign fetchCount             = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed corner sequences, a decision table, and a randomized scoreboard run.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, rv, rj, ack, pcs, rdy;
    logic [11:0] roff;
    logic [15:0] pcin;
    logic        readInstruction, resetInstructionMemory, branchExecute, jumpExecute;
    logic [5:0]  offset;
    logic [11:0] offsetJump;
    logic [15:0] instrOut;
    logic        instrValid, redirectAccepted, halted;
    logic [15:0] fetchCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.COL(16), .TIMEOUT(8)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .enable                 (en),
        .readInstruction        (readInstruction),
        .resetInstructionMemory (resetInstructionMemory),
        .branchExecute          (branchExecute),
        .jumpExecute            (jumpExecute),
        .offset                 (offset),
        .offsetJump             (offsetJump),
        .pc_instr               (pcin),
        .readInstructionComplete(ack),
        .pcSetForBranch         (pcs),
        .instrOut               (instrOut),
        .instrValid             (instrValid),
        .instrReady             (rdy),
        .redirectValid          (rv),
        .redirectIsJump         (rj),
        .redirectOffset         (roff),
        .redirectAccepted       (redirectAccepted),
        .halted                 (halted),
        .fetchCount             (fetchCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_rd"},  32'(readInstruction), 0);
        chk({name, "_rim"}, 32'(resetInstructionMemory), 0);
        chk({name, "_br"},  32'(branchExecute), 0);
        chk({name, "_jp"},  32'(jumpExecute), 0);
        chk({name, "_val"}, 32'(instrValid), 0);
        chk({name, "_acc"}, 32'(redirectAccepted), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; rv = 1'b0; rj = 1'b0; roff = '0;
        ack = 1'b0; pcs = 1'b0; rdy = 1'b0; pcin = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // From the cycle the FSM sits in REQ: ack immediately, land in HOLD
    task automatic goto_hold(input logic [15:0] d);
        ack = 1'b1; pcin = d;
        step();
        step();
        ack = 1'b0;
        step();
    endtask

    typedef struct {
        logic        rv, rj, en, rdy;
        logic [11:0] off;
        logic        e_acc, e_rd, e_val, e_br, e_jp;
        logic [15:0] e_cnt;
    } tv_t;
    tv_t tv[8];

    logic [15:0] exp_q[$];
    logic [15:0] exp_word;
    logic        exp_clr, acc_prev, pend_j, acc_now;
    logic [11:0] pend_off;
    logic [15:0] model_cnt;
    int          rd_cnt, lat, pc_cd, rv_age;
    logic        en_n, rv_n, rj_n, ack_n, pcs_n, rdy_n;
    logic [11:0] roff_n;
    logic [15:0] pcin_n;

    initial begin
        // fields: rv rj en rdy off | acc rd val br jp cnt
        tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tv[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h3F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h02A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
        tv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'hFC1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};

        // Reset state, with provocative inputs held
        rst_n = 1'b0; en = 1'b1; rv = 1'b1; rj = 1'b1; roff = 12'hABC;
        ack = 1'b1; pcs = 1'b1; rdy = 1'b1; pcin = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("rst");
        chk("rst_halt",  32'(halted), 0);
        chk("rst_cnt",   32'(fetchCount), 0);
        chk("rst_instr", 32'(instrOut), 0);
        chk("rst_off",   32'(offset), 0);
        chk("rst_offj",  32'(offsetJump), 0);
        do_reset();

        // Basic fetch, ack one cycle after request
        en = 1'b1; #1;
        chk("f_idle_rd", 32'(readInstruction), 0);
        step(); ack = 1'b1; pcin = 16'hA5C3; #1;
        chk("f_req_rd", 32'(readInstruction), 1);
        chk("f_req_val", 32'(instrValid), 0);
        step(); #1;
        chk("f_wait_rd", 32'(readInstruction), 1);
        step(); ack = 1'b0; rdy = 1'b1; #1;
        chk("f_clr_rd", 32'(readInstruction), 0);
        chk("f_clr_rim", 32'(resetInstructionMemory), 1);
        chk("f_clr_instr", 32'(instrOut), 32'h0000A5C3);
        step(); #1;
        chk("f_hold_rim", 32'(resetInstructionMemory), 0);
        chk("f_hold_val", 32'(instrValid), 1);
        chk("f_hold_cnt", 32'(fetchCount), 0);
        step(); #1;
        chk("f_hs_cnt", 32'(fetchCount), 1);
        chk("f_hs_rd", 32'(readInstruction), 1);
        chk("f_hs_val", 32'(instrValid), 0);
        // enable dropped during the second transaction
        en = 1'b0; ack = 1'b1; pcin = 16'h1234;
        step(); step(); ack = 1'b0;
        step(); #1;
        chk("e_hold_instr", 32'(instrOut), 32'h00001234);
        chk("e_hold_val", 32'(instrValid), 1);
        step(); #1;
        chk("e_idle_rd", 32'(readInstruction), 0);
        chk("e_idle_cnt", 32'(fetchCount), 2);
        step(); #1;
        chk("e_idle2_rd", 32'(readInstruction), 0);

        // Jump redirect accepted from IDLE
        rv = 1'b1; rj = 1'b1; roff = 12'h3F0; #1;
        chk("j_acc", 32'(redirectAccepted), 1);
        step(); rv = 1'b0; #1;
        chk("j_jp", 32'(jumpExecute), 1);
        chk("j_br", 32'(branchExecute), 0);
        chk("j_offj", 32'(offsetJump), 32'h3F0);
        chk("j_acc_off", 32'(redirectAccepted), 0);
        step(); #1;
        chk("j_jp_pulse", 32'(jumpExecute), 0);
        chk("j_offj_hold", 32'(offsetJump), 32'h3F0);
        pcs = 1'b1; en = 1'b1;
        step(); pcs = 1'b0; #1;
        chk("j_refetch", 32'(readInstruction), 1);
        chk("j_offj_keep", 32'(offsetJump), 32'h3F0);

        // Branch redirect accepted on a HOLD handshake
        goto_hold(16'hBEEF); #1;
        chk("b_hold_instr", 32'(instrOut), 32'h0000BEEF);
        rv = 1'b1; rj = 1'b0; roff = 12'h005; rdy = 1'b1; #1;
        chk("b_acc", 32'(redirectAccepted), 1);
        step(); rv = 1'b0; rdy = 1'b0; #1;
        chk("b_br", 32'(branchExecute), 1);
        chk("b_jp", 32'(jumpExecute), 0);
        chk("b_off", 32'(offset), 32'h05);
        chk("b_cnt", 32'(fetchCount), 3);
        step(); #1;
        chk("b_br_pulse", 32'(branchExecute), 0);
        chk("b_off_hold", 32'(offset), 32'h05);
        chk("b_waitpc_rd", 32'(readInstruction), 0);
        step(); #1;
        chk("b_waitpc2_rd", 32'(readInstruction), 0);
        pcs = 1'b1;
        step(); pcs = 1'b0; #1;
        chk("b_refetch", 32'(readInstruction), 1);

        // Ack timeout: eight unanswered WAIT_ACK cycles, then HALT
        for (int i = 1; i <= 8; i++) begin
            step(); #1;
            chk($sformatf("t_wait%0d_rd", i), 32'(readInstruction), 1);
            chk($sformatf("t_wait%0d_halt", i), 32'(halted), 0);
        end
        step(); #1;
        chk("t_halted", 32'(halted), 1);
        chk("t_rd", 32'(readInstruction), 0);
        en = 1'b1; ack = 1'b1; rv = 1'b1; rj = 1'b1; pcs = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t_sticky", 32'(halted), 1);
            chk_quiet("t_halt");
        end

        // Asynchronous reset during WAIT_ACK
        do_reset();
        en = 1'b1;
        step();
        goto_hold(16'h7E01);
        rdy = 1'b1;
        step(); rdy = 1'b0;
        step(); #1;
        chk("r_wait_rd", 32'(readInstruction), 1);
        chk("r_wait_cnt", 32'(fetchCount), 1);
        rst_n = 1'b0; #1;
        chk_quiet("r_async");
        chk("r_async_cnt", 32'(fetchCount), 0);
        chk("r_async_instr", 32'(instrOut), 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; en = 1'b0; #1;
        chk("r_rel_rd", 32'(readInstruction), 0);
        step(); #1;
        chk("r_idle_rd", 32'(readInstruction), 0);
        en = 1'b1;
        step(); #1;
        chk("r_idle_req", 32'(readInstruction), 1);

        // fetchCount wrap
        goto_hold(16'h55AA);
        force dut.r_fetch_count = 16'hFFFF;
        #1;
        release dut.r_fetch_count;
        #1;
        chk("w_preload", 32'(fetchCount), 32'hFFFF);
        rdy = 1'b1;
        step(); rdy = 1'b0; #1;
        chk("w_wrap", 32'(fetchCount), 0);

        // Decision table applied on a HOLD cycle
        for (int i = 0; i < 8; i++) begin
            do_reset();
            en = 1'b1;
            step();
            goto_hold(16'h1000 + 16'(i));
            #1;
            chk($sformatf("tv%0d_hold", i), 32'(instrValid), 1);
            rv = tv[i].rv; rj = tv[i].rj; roff = tv[i].off; en = tv[i].en; rdy = tv[i].rdy;
            #1;
            chk($sformatf("tv%0d_acc", i), 32'(redirectAccepted), 32'(tv[i].e_acc));
            step(); rv = 1'b0; rdy = 1'b0; #1;
            chk($sformatf("tv%0d_rd", i), 32'(readInstruction), 32'(tv[i].e_rd));
            chk($sformatf("tv%0d_val", i), 32'(instrValid), 32'(tv[i].e_val));
            chk($sformatf("tv%0d_br", i), 32'(branchExecute), 32'(tv[i].e_br));
            chk($sformatf("tv%0d_jp", i), 32'(jumpExecute), 32'(tv[i].e_jp));
            chk($sformatf("tv%0d_cnt", i), 32'(fetchCount), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d_instr", i), 32'(instrOut), 32'h1000 + 32'(i));
            if (tv[i].e_br) chk($sformatf("tv%0d_off", i), 32'(offset), 32'(tv[i].off[5:0]));
            if (tv[i].e_jp) chk($sformatf("tv%0d_offj", i), 32'(offsetJump), 32'(tv[i].off));
        end

        // Randomized run against a transaction-level scoreboard
        do_reset();
        en = 1'b1;
        exp_q.delete();
        exp_clr = 1'b0; acc_prev = 1'b0; pend_j = 1'b0; pend_off = '0;
        model_cnt = '0; rd_cnt = 0; lat = 1; pc_cd = 0; rv_age = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_halted", 32'(halted), 0);
            chk("rnd_clr", 32'(resetInstructionMemory), 32'(exp_clr));
            chk("rnd_br", 32'(branchExecute), 32'(acc_prev & ~pend_j));
            chk("rnd_jp", 32'(jumpExecute), 32'(acc_prev & pend_j));
            if (acc_prev) begin
                chk("rnd_off", 32'(offset), 32'(pend_off[5:0]));
                chk("rnd_offj", 32'(offsetJump), 32'(pend_off));
            end
            chk("rnd_count", 32'(fetchCount), 32'(model_cnt));

            exp_clr = readInstruction & ack;
            if (exp_clr) exp_q.push_back(pcin);
            if (instrValid && rdy) begin
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                chk("rnd_instr", 32'(instrOut), 32'(exp_word));
                model_cnt = model_cnt + 16'd1;
            end

            acc_now = redirectAccepted;
            rv_n = rv; rj_n = rj; roff_n = roff;
            if (acc_now) begin
                chk("rnd_acc_valid", 32'(rv), 1);
                pend_j = rj; pend_off = roff;
                rv_n = 1'b0; rv_age = 0;
            end else if (rv) begin
                rv_age++;
                if (rv_age == 100) chk("rnd_acc_timeout", 32'(rv_age), 0);
            end else if ($urandom_range(9) == 0) begin
                rv_n = 1'b1; rj_n = 1'($urandom_range(1)); roff_n = 12'($urandom);
            end
            acc_prev = acc_now;

            ack_n = ack; pcin_n = pcin;
            if (resetInstructionMemory) begin
                ack_n = 1'b0; rd_cnt = 0;
            end else if (readInstruction && !ack) begin
                rd_cnt++;
                if (rd_cnt >= lat) begin
                    ack_n = 1'b1; pcin_n = 16'($urandom); lat = $urandom_range(1, 5);
                end
            end

            pcs_n = 1'b0;
            if (branchExecute || jumpExecute) pc_cd = $urandom_range(1, 5);
            if (pc_cd > 0) begin
                pc_cd--;
                if (pc_cd == 0) pcs_n = 1'b1;
            end

            rdy_n = ($urandom_range(3) != 0);
            en_n  = ($urandom_range(15) == 0) ? ~en : en;

            @(posedge clk);
            #1;
            en = en_n; rv = rv_n; rj = rj_n; roff = roff_n;
            ack = ack_n; pcin = pcin_n; pcs = pcs_n; rdy = rdy_n;
        end
        chk("rnd_progress", 32'(model_cnt > 16'd100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter COL, default 16, instruction width in bits.
REQ-002 Parameter TIMEOUT, default 8, maximum cycles to wait for a memory acknowledge.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 enable  in  1  level; 1 = keep fetching.
REQ-006 readInstruction  out  1  read request to the instruction memory; level.
REQ-007 resetInstructionMemory  out  1  one-cycle pulse that clears the memory's complete flag.
REQ-008 branchExecute  out  1  one-cycle pulse requesting pc = pc + offset.
REQ-009 jumpExecute  out  1  one-cycle pulse requesting pc[11:0] = offsetJump.
REQ-010 offset  out  6  branch offset.
REQ-011 offsetJump  out  12  jump target.
REQ-012 pc_instr  in  COL  instruction returned by memory.
REQ-013 readInstructionComplete  in  1  memory acknowledge; level.
REQ-014 pcSetForBranch  in  1  memory redirect acknowledge; level.
REQ-015 instrOut  out  COL  captured instruction to the decoder.
REQ-016 instrValid  out  1  instrOut is valid.
REQ-017 instrReady  in  1  decoder accepts instrOut.
REQ-018 redirectValid, redirectIsJump, redirectOffset[11:0]  in  redirect request from execute; held stable until accepted.
REQ-019 redirectAccepted  out  1  one-cycle pulse marking redirect acceptance.
REQ-020 halted  out  1  sticky error flag.
REQ-021 fetchCount  out  16  count of instructions handed to the decoder.

Function
REQ-022 FSM states: IDLE, REQ, WAIT_ACK, CLEAR, HOLD, REDIRECT, WAIT_PC, HALT.
REQ-023 IDLE: redirectValid=1 -> REDIRECT; otherwise enable=1 -> REQ; redirect has priority.
REQ-024 REQ: readInstruction=1; next state WAIT_ACK; wait counter cleared.
REQ-025 WAIT_ACK: readInstruction held 1; readInstructionComplete=1 -> capture pc_instr into instrOut, readInstruction=0 next cycle, -> CLEAR.
REQ-026 WAIT_ACK: if the wait counter reaches TIMEOUT without an acknowledge -> HALT.
REQ-027 CLEAR: resetInstructionMemory=1 for exactly one cycle; -> HOLD.
REQ-028 HOLD: instrValid=1 and instrOut stable until a cycle with instrReady=1.
REQ-029 HOLD handshake cycle: fetchCount increments; next state is REDIRECT if redirectValid, else REQ if enable, else IDLE.
REQ-030 Redirect acceptance occurs only in IDLE or on a HOLD handshake cycle; it raises redirectAccepted for one cycle and latches the redirect fields.
REQ-031 REDIRECT, jump: jumpExecute=1 for one cycle, offsetJump=latched offset. Branch: branchExecute=1 for one cycle, offset=latched[5:0]. Then -> WAIT_PC.
REQ-032 offset and offsetJump remain stable from REDIRECT until WAIT_PC exits.
REQ-033 WAIT_PC: pcSetForBranch=1 -> REQ if enable, else IDLE. Timeout as in REQ-026 -> HALT.
REQ-034 HALT: halted=1; every strobe is 0; the state persists until reset.
REQ-035 Request-to-capture latency is 2 cycles minimum (REQ, WAIT_ACK with ack present).
REQ-036 enable deasserted mid-transaction: the current transaction completes through HOLD, then the FSM goes to IDLE.
REQ-037 fetchCount wraps from 0xFFFF to 0x0000.
REQ-038 The wait counter is 4 bits and saturates.
REQ-039 branchExecute and jumpExecute are never asserted in the same cycle.

Reset
REQ-040 While rst_n=0: state is IDLE; every output, fetchCount, instrOut, the latched redirect fields and the wait counter are 0.
REQ-041 Reset asserted mid-transaction aborts the transaction immediately with no further strobes.

Structure
REQ-042 COL, TIMEOUT and the state encodings belong in the shared parameter header.
REQ-043 The wait counter is the sub-module fetch_timeout_counter, with clear, count-enable and expired outputs.

Verification
REQ-044 Memory acks 1 cycle after request with 16'hA5C3, instrReady=1 -> instrOut=16'hA5C3, one resetInstructionMemory pulse, fetchCount=1.
REQ-045 Branch redirect with offset 12'h005 while in HOLD -> redirectAccepted pulse, branchExecute pulse, offset=6'h05, refetch after pcSetForBranch.
REQ-046 Jump redirect with offset 12'h3F0 from IDLE -> jumpExecute pulse, offsetJump=12'h3F0, jumpExecute and branchExecute never both 1.
REQ-047 No acknowledge for 8 cycles -> halted=1, readInstruction=0, state held.
REQ-048 rst_n pulled low during WAIT_ACK -> all outputs 0 asynchronously, IDLE after release.
REQ-049 Preload fetchCount to 0xFFFF and complete one handshake -> fetchCount=0x0000.
